id_issue_fifo: RTL
==================

# id_issue_fifo

Decoupling buffer between the ID stage and the ROB stage. It captures one decoded instruction per cycle (PC, the `opgen` operation code, operand/destination register addresses, immediate) through a valid/ready handshake. It presents entries in program order to the ROB allocator, which can stall without back-pressuring decode until the buffer fills. A flush input discards all buffered instructions on branch misprediction or exception.

## Interface

- `DEPTH`, 4 — number of entries; power of two, ≥ 2.
- `OPGEN_W`, 6 — width of `opgen` (matches `OPGEN_BUS`).
- `ADDR_W`, 32 — PC and immediate width.
- `REG_W`, 5 — register address width (matches `REG_ADDR_BUS`).
- One clock; reset is asynchronous and active-high.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous flush; discard all entries.
- `id_valid`  in  1  ID presents an instruction.
- `id_ready`  out  1  buffer accepts this cycle.
- `id_pc`  in  ADDR_W  instruction PC.
- `id_opgen`  in  OPGEN_W  operation code from the op generator.
- `id_rs`, `id_rt`  in  REG_W  source register addresses.
- `id_dst`  in  REG_W  destination register address.
- `id_dst_en`  in  1  instruction writes `id_dst`.
- `id_imm`  in  ADDR_W  extended immediate.
- `rob_valid`  out  1  head entry available.
- `rob_ready`  in  1  ROB consumes head this cycle.
- `rob_pc`, `rob_opgen`, `rob_rs`, `rob_rt`, `rob_dst`, `rob_dst_en`, `rob_imm`  out  same widths as `id_*`  head entry fields.
- `count`  out  log2(DEPTH)+1  occupied entries.

## Operation

- Circular buffer: `DEPTH` entries, write pointer `wp`, read pointer `rp` (log2(DEPTH) bits, wrap naturally), occupancy counter `count`.
- Push = `id_valid & id_ready`. Entry written at `wp`, `wp` += 1.
- Pop = `rob_valid & rob_ready`. `rp` += 1.
- `id_ready` = (`count` != DEPTH). Computed from registered count only. A pop in the same cycle does not free a slot for a push when full.
- `rob_valid` = (`count` != 0). No bypass: a push into an empty buffer is not visible the same cycle.
- `rob_*` fields are read combinationally from entry `rp` when `rob_valid`. They are forced to all-zero when `rob_valid` = 0.
- `count` update: push only +1; pop only −1; push and pop together unchanged.
- `rob_ready` while `rob_valid` = 0 is ignored. `id_valid` while `id_ready` = 0 is ignored; ID must hold its payload.
- Every `opgen` value, including NOP, is buffered unchanged. The block does not decode or filter.
- Flush has priority over push and pop. On a rising edge with `flush` = 1: `wp` = `rp` = 0, `count` = 0, and any concurrent push/pop is discarded. Entry storage need not be cleared.
- Reset clears `wp`, `rp`, `count` and all entry storage to 0.

## Timing

- Reset values: `id_ready` = 1, `rob_valid` = 0, `count` = 0, all `rob_*` fields = 0. Outputs are valid immediately on `rst` assertion, without waiting for a clock edge.
- Push-to-head latency: 1 cycle. An instruction pushed at edge N appears on `rob_*` with `rob_valid` = 1 after edge N (if the buffer was empty).
- Throughput: 1 push and 1 pop per cycle in steady state, provided 0 < `count` < DEPTH.
- After a flush edge: `rob_valid` = 0 and `id_ready` = 1 in the following cycle.
- `rst` asserted mid-transfer: state clears asynchronously. The transfer is lost, and no entry is written on that edge.

## Test plan

- Reset: assert `rst` mid-cycle. Required: `id_ready` = 1, `rob_valid` = 0, `count` = 0, `rob_pc` = 0 with no clock edge.
- Fill: push PCs 0x100, 0x104, 0x108, 0x10C with `rob_ready` = 0. Required: `count` 1→4, `id_ready` = 0 after the 4th edge, `rob_pc` = 0x100 throughout.
- Full with simultaneous push and pop: `id_valid` = 1 (PC 0x110), `rob_ready` = 1. Required: only the pop occurs, `count` = 3, `rob_pc` = 0x104, `id_ready` = 1 next cycle, 0x110 not stored.
- Mid-level steady stream: `count` = 2, push and pop every cycle for 8 cycles. Required: `count` stays 2. Pops appear in push order, exercising pointer wrap past `DEPTH`.
- Flush: `count` = 3, assert `flush` together with a push (PC 0x200) and `rob_ready` = 1. Required: next cycle `count` = 0, `rob_valid` = 0, all `rob_*` = 0; 0x200 is absent from later pops.
- Ordering/payload: push 10 instructions with distinct `opgen`/`rs`/`rt`/`dst`/`dst_en`/`imm`, random `rob_ready`. Required: all fields are popped bit-exact, in order, with no loss or duplication.

Source files
------------

// File: rtl/id_issue_fifo.sv
`default_nettype none
// ============================================================================
// id_issue_fifo : in-order ID -> ROB decoupling buffer, valid/ready on both
//                 sides, synchronous flush and asynchronous reset.
// Revision 1.0
// ============================================================================
module id_issue_fifo #(
   parameter int DEPTH   = 4,
   parameter int OPGEN_W = 6,
   parameter int ADDR_W  = 32,
   parameter int REG_W   = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     id_valid,
   output logic                     id_ready,
   input  logic [ADDR_W-1:0]        id_pc,
   input  logic [OPGEN_W-1:0]       id_opgen,
   input  logic [REG_W-1:0]         id_rs,
   input  logic [REG_W-1:0]         id_rt,
   input  logic [REG_W-1:0]         id_dst,
   input  logic                     id_dst_en,
   input  logic [ADDR_W-1:0]        id_imm,
   output logic                     rob_valid,
   input  logic                     rob_ready,
   output logic [ADDR_W-1:0]        rob_pc,
   output logic [OPGEN_W-1:0]       rob_opgen,
   output logic [REG_W-1:0]         rob_rs,
   output logic [REG_W-1:0]         rob_rt,
   output logic [REG_W-1:0]         rob_dst,
   output logic                     rob_dst_en,
   output logic [ADDR_W-1:0]        rob_imm,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int             PTR_W  = $clog2(DEPTH);
   localparam int             ENT_W  = 2*ADDR_W + OPGEN_W + 3*REG_W + 1;
   localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0] wp_q, wp_d;
   logic [PTR_W-1:0] rp_q, rp_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [ENT_W-1:0] mem_d [DEPTH];

   logic             push;
   logic             pop;
   logic [ENT_W-1:0] wr_entry;
   logic [ENT_W-1:0] head;

   // Handshakes look only at registered occupancy, so a pop never frees a
   // slot for a push in the same cycle.
   assign id_ready  = (count_q != C_FULL);
   assign rob_valid = (count_q != '0);
   assign push      = id_valid & id_ready;
   assign pop       = rob_valid & rob_ready;
   assign count     = count_q;

   assign wr_entry = {id_pc, id_opgen, id_rs, id_rt, id_dst, id_dst_en, id_imm};
   assign head     = rob_valid ? mem_q[rp_q] : '0;
   assign {rob_pc, rob_opgen, rob_rs, rob_rt, rob_dst, rob_dst_en, rob_imm} = head;

   always_comb begin
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      mem_d   = mem_q;
      if (flush) begin
         wp_d    = '0;
         rp_d    = '0;
         count_d = '0;
      end else begin
         if (push) begin
            mem_d[wp_q] = wr_entry;
            wp_d        = wp_q + PTR_W'(1);
         end
         if (pop) begin
            rp_d = rp_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            mem_q[gi] <= '0;
         end else begin
            mem_q[gi] <= mem_d[gi];
         end
      end
   end

endmodule
`default_nettype wire
